// File: rtl/test_status_responder.sv
// test_status_responder
//
// Terminates a target's "tohost" status channel on behalf of a test driver.
// The target posts 64-bit status words. The block decodes each accepted word:
//   0            : ignored, stay running
//   1            : test passed            -> PASS (terminal)
//   odd, != 1    : test failed, code=d>>1 -> FAIL (terminal)
//   even, != 0   : needs acknowledgement  -> ACK, offer fromhost word 1
// An optional idle watchdog declares failure (timeout=1, fail_code=0) once
// TIMEOUT_CYCLES consecutive cycles pass in RUN/ACK without any transfer or
// acknowledge handshake.
//
// Handshake semantics (both channels): a word moves on a rising clock edge
// where valid and ready are both high. The producer holds valid and data
// stable until that edge. Ready never depends combinationally on valid.
//
// Ports:
//   clock, reset_n      clock; asynchronous active-low reset
//   tohost_valid/ready/data      status word from target (data 64 bits)
//   fromhost_valid/ready/data    acknowledge word to target (data 64 bits)
//   success, failure    sticky terminal indications (mutually exclusive)
//   timeout             failure came from the watchdog
//   fail_code           data[63:1] of the failing status word, 0 on timeout
//   cycles              RUN/ACK cycles since reset release, saturating
//   dbg_state           current FSM state, for debug and checkers
//
// All outputs are registered; nothing is a combinational function of inputs.

module test_status_responder #(
  parameter int TIMEOUT_CYCLES = 0,
  parameter int CNT_W          = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             tohost_valid,
  output logic             tohost_ready,
  input  logic [63:0]      tohost_data,
  output logic             fromhost_valid,
  input  logic             fromhost_ready,
  output logic [63:0]      fromhost_data,
  output logic             success,
  output logic             failure,
  output logic             timeout,
  output logic [62:0]      fail_code,
  output logic [CNT_W-1:0] cycles,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_ACK  = 2'd1,
    S_PASS = 2'd2,
    S_FAIL = 2'd3
  } state_t;

  state_t state_q;

  logic xfer;
  logic ack_hs;
  logic active;
  logic wd_expire;

  // tohost_ready is only ever high in RUN, and fromhost_valid only in ACK,
  // so these two strobes are already qualified by state.
  assign xfer   = tohost_valid && tohost_ready;
  assign ack_hs = fromhost_valid && fromhost_ready;
  assign active = (state_q == S_RUN) || (state_q == S_ACK);

  assign dbg_state = state_q;

  // Watchdog: counts idle RUN/ACK cycles. It expires on the edge that would
  // complete the TIMEOUT_CYCLES-th consecutive idle cycle, so any transfer or
  // handshake on that same edge wins.
  generate
    if (TIMEOUT_CYCLES > 0) begin : g_wd
      localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
      localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

      logic [WD_W-1:0] wd_cnt;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          wd_cnt <= '0;
        end else if (xfer || ack_hs) begin
          wd_cnt <= '0;
        end else if (active) begin
          wd_cnt <= wd_cnt + 1'b1;
        end
      end

      assign wd_expire = active && !xfer && !ack_hs && (wd_cnt == WD_LAST);
    end else begin : g_no_wd
      assign wd_expire = 1'b0;
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_RUN;
      tohost_ready   <= 1'b0;
      fromhost_valid <= 1'b0;
      fromhost_data  <= 64'd0;
      success        <= 1'b0;
      failure        <= 1'b0;
      timeout        <= 1'b0;
      fail_code      <= 63'd0;
      cycles         <= '0;
    end else begin
      // Cycle counter freezes once a terminal state is reached.
      if (active && (cycles != '1)) begin
        cycles <= cycles + 1'b1;
      end

      unique case (state_q)
        S_RUN: begin
          // Default: keep accepting. This also raises ready on the first
          // edge after reset release.
          tohost_ready <= 1'b1;
          if (xfer) begin
            if (tohost_data == 64'd0) begin
              state_q <= S_RUN;
            end else if (tohost_data == 64'd1) begin
              state_q      <= S_PASS;
              tohost_ready <= 1'b0;
              success      <= 1'b1;
            end else if (tohost_data[0]) begin
              state_q      <= S_FAIL;
              tohost_ready <= 1'b0;
              failure      <= 1'b1;
              timeout      <= 1'b0;
              fail_code    <= tohost_data[63:1];
            end else begin
              state_q        <= S_ACK;
              tohost_ready   <= 1'b0;
              fromhost_valid <= 1'b1;
              fromhost_data  <= 64'd1;
            end
          end else if (wd_expire) begin
            state_q      <= S_FAIL;
            tohost_ready <= 1'b0;
            failure      <= 1'b1;
            timeout      <= 1'b1;
            fail_code    <= 63'd0;
          end
        end

        S_ACK: begin
          if (ack_hs) begin
            state_q        <= S_RUN;
            tohost_ready   <= 1'b1;
            fromhost_valid <= 1'b0;
            fromhost_data  <= 64'd0;
          end else if (wd_expire) begin
            state_q        <= S_FAIL;
            fromhost_valid <= 1'b0;
            fromhost_data  <= 64'd0;
            failure        <= 1'b1;
            timeout        <= 1'b1;
            fail_code      <= 63'd0;
          end
        end

        // Terminal until reset: every output simply holds.
        S_PASS: state_q <= S_PASS;
        S_FAIL: state_q <= S_FAIL;

        default: state_q <= S_RUN;
      endcase
    end
  end

endmodule
